bus_write_arbiter: RTL and testbench
====================================

# bus_write_arbiter

- Round-robin scheduler for the shared intra-PU data bus: NUM_PE processing elements post words for the bus, and one word per cycle is granted and broadcast with a one-hot destination mask.
- Sits between the PE write ports and the per-PE bus read buffers; each buffer's registered full flag is fed back as backpressure.
- Also provides a pending-work indication and a sticky stuck-bus error for the PU controller.

## Interface
- NUM_PE, 8: number of requesters and destinations; must equal 2^BUS_ADDR_LEN.
- DATA_LEN, 16: bus data width.
- BUS_ADDR_LEN, 3: source-id width carried on the bus.
- STUCK_LIMIT, 1024: consecutive blocked cycles before err_stuck is set; counter width is C_LOG_2(STUCK_LIMIT)+1.

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- stall  in  1  global pipeline stall; no grants while high
- req  in  NUM_PE  per-PE request, held until granted
- req_data  in  NUM_PE*DATA_LEN  per-PE word, slice i belongs to PE i
- req_dst  in  NUM_PE*NUM_PE  per-PE one-hot or multi-hot destination mask, slice i belongs to PE i
- dst_full  in  NUM_PE  rd_buffer_full from each destination buffer
- gnt  out  NUM_PE  one-hot grant, combinational, same cycle as selection
- bus_data  out  DATA_LEN  registered broadcast data
- bus_addr  out  BUS_ADDR_LEN  registered source PE id of bus_data
- bus_valid  out  NUM_PE  registered per-destination valid, equal to the destination mask of the winner
- busy  out  1  registered OR of req
- err_stuck  out  1  sticky; cleared only by reset

## Operation
- PE i is eligible when all three hold: req[i]=1, req_dst slice i is nonzero, and (req_dst slice i & dst_full)=0.
- A word with a zero destination mask is never eligible; it contributes to stuck detection.
- Selection: when stall=0, the first eligible PE searching upward from ptr, wrapping from NUM_PE-1 to 0, is granted. gnt has exactly one bit set.
- When stall=1 or no PE is eligible: gnt=0.
- Round-robin pointer ptr (BUS_ADDR_LEN bits):
  - On a grant to PE k, ptr becomes (k+1) mod NUM_PE.
  - Otherwise ptr holds.
  - Every eligible PE is therefore served within NUM_PE grants.
- Bus register, updated every cycle:
  - On a grant to k: bus_data ← req_data slice k, bus_addr ← k, bus_valid ← req_dst slice k.
  - Otherwise bus_valid ← 0, and bus_data and bus_addr hold.
- Requester handshake: a requester holds req, data and destination until it sees gnt[i]=1 in a cycle. It may present a new word in the following cycle; back-to-back grants to the same PE are legal.
- Backpressure: dst_full is one cycle stale. Each destination buffer absorbs the one word that can arrive in the cycle after it goes full (two-stage input pipeline). The arbiter adds no guard of its own.
- Stuck detector, counter blk_cnt:
  - When busy_next=1 and no grant occurs: blk_cnt increments, saturating at STUCK_LIMIT.
  - On any grant, or when req=0: blk_cnt clears.
  - Stall cycles freeze blk_cnt.
  - When blk_cnt reaches STUCK_LIMIT, err_stuck is set; it stays set until rstn.

## Timing
- Reset values: ptr=0, bus_data=0, bus_addr=0, bus_valid=0, busy=0, blk_cnt=0, err_stuck=0.
- gnt is combinational in cycle t. The corresponding bus word is visible in cycle t+1, so latency from request to bus is 1 cycle when uncontended.
- Throughput: one word per cycle when the eligible set is nonempty and stall=0.
- Stall rising in cycle t: no grant in t, bus_valid=0 in t+1. A word already on the bus in t is unaffected.
- dst_full rising in cycle t: requesters targeting that destination are ineligible from t. A grant issued in t-1 still lands in t.
- Reset asserted mid-transfer: all registers clear asynchronously and the in-flight bus word is dropped. Requesters must re-request after reset.
- When dst_full changes and req_dst changes in the same cycle, the current-cycle values of both are used.

## Structure
- Shared package or include: C_LOG_2 (log.vh), BUS_ADDR_LEN and NUM_PE defaults, and the STUCK_LIMIT constant.
- One sub-module, rr_priority_pick:
  - Inputs: eligible vector and ptr.
  - Outputs: one-hot winner and winner index.
  - Implementation: double-width rotate-mask priority encoder; purely combinational.
- Top module contains the eligibility logic, ptr, the bus output register, busy, and the stuck counter.

## Test plan
- Reset, then single request: after rstn, req=8'h04, req_data slice 2=16'hBEEF, req_dst slice 2=8'h10 → gnt=8'h04 same cycle; next cycle bus_data=BEEF, bus_addr=2, bus_valid=8'h10; ptr=3.
- Full contention, fairness: req=8'hFF held, all destinations free, each PE re-requests after its grant → grants in order 0,1,…,7,0, one per cycle, with no gaps.
- Backpressure: PEs 1 and 5 request; PE 1 targets destination 3, dst_full[3]=1 → PE 5 granted; after dst_full[3] drops, PE 1 is granted the next cycle.
- Stall: stall=1 for 4 cycles with req=8'h0F → gnt=0 and bus_valid=0 throughout, blk_cnt unchanged; first cycle after stall drops → gnt=8'h01.
- Stuck detection: STUCK_LIMIT=16, req=8'h01 with its destination permanently full → err_stuck=1 after exactly 16 blocked cycles; remains 1 after req drops until rstn.
- Zero destination mask: req[0]=1 with req_dst slice 0=0, req[1]=1 valid → PE 1 granted; PE 0 is never granted.

Source files
------------

// File: rtl/bus_write_arbiter_pkg.sv
// Shared constants and helpers for the intra-PU bus write arbiter.
// Default geometry and the stuck-bus threshold live here.
package bus_write_arbiter_pkg;

    localparam int NUM_PE_DEF       = 8;
    localparam int DATA_LEN_DEF     = 16;
    localparam int BUS_ADDR_LEN_DEF = 3;
    localparam int STUCK_LIMIT_DEF  = 1024;

    // ceil(log2(value)), usable in parameter expressions
    function automatic int c_log_2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_write_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first set bit of elig at or above ptr,
// wrapping, via a double-width rotate-mask priority encoder.
module rr_priority_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win,
    output logic [W-1:0] win_idx
);

    localparam logic [N-1:0]   ONE_N  = N'(1);
    localparam logic [2*N-1:0] ONE_2N = (2*N)'(1);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] low;

    // lower half keeps bits >= ptr, upper half is the wrapped copy
    always_comb begin
        hi_mask = ~((ONE_N << ptr) - ONE_N);
        dbl     = {elig, elig & hi_mask};
        low     = dbl & (~dbl + ONE_2N);
        win     = low[N-1:0] | low[2*N-1:N];
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) win_idx = W'(i);
        end
    end

endmodule

// File: rtl/bus_write_arbiter.sv
// Round-robin write scheduler for the shared intra-PU data bus.
// One word per cycle is granted and broadcast with its dest mask.
module bus_write_arbiter
    import bus_write_arbiter_pkg::*;
#(
    parameter int NUM_PE       = NUM_PE_DEF,
    parameter int DATA_LEN     = DATA_LEN_DEF,
    parameter int BUS_ADDR_LEN = BUS_ADDR_LEN_DEF,
    parameter int STUCK_LIMIT  = STUCK_LIMIT_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       stall,
    input  logic [NUM_PE-1:0]          req,
    input  logic [NUM_PE*DATA_LEN-1:0] req_data,
    input  logic [NUM_PE*NUM_PE-1:0]   req_dst,
    input  logic [NUM_PE-1:0]          dst_full,
    output logic [NUM_PE-1:0]          gnt,
    output logic [DATA_LEN-1:0]        bus_data,
    output logic [BUS_ADDR_LEN-1:0]    bus_addr,
    output logic [NUM_PE-1:0]          bus_valid,
    output logic                       busy,
    output logic                       err_stuck
);

    localparam int CNT_W = c_log_2(STUCK_LIMIT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUCK_LIMIT);

    logic [NUM_PE-1:0]       elig;
    logic [BUS_ADDR_LEN-1:0] ptr;
    logic [BUS_ADDR_LEN-1:0] win_idx;
    logic [CNT_W-1:0]        blk_cnt;
    logic [CNT_W-1:0]        blk_nxt;
    logic                    any_gnt;
    logic                    busy_next;

    // eligible: requesting, nonzero mask, no targeted buffer full
    always_comb begin
        elig = '0;
        if (!stall) begin
            for (int i = 0; i < NUM_PE; i++) begin
                elig[i] = req[i]
                    && (|req_dst[i*NUM_PE +: NUM_PE])
                    && !(|(req_dst[i*NUM_PE +: NUM_PE] & dst_full));
            end
        end
    end

    rr_priority_pick #(
        .N (NUM_PE),
        .W (BUS_ADDR_LEN)
    ) u_pick (
        .elig    (elig),
        .ptr     (ptr),
        .win     (gnt),
        .win_idx (win_idx)
    );

    assign any_gnt   = |gnt;
    assign busy_next = |req;

    // blocked-cycle count: frozen by stall, cleared by grant or idle
    always_comb begin
        blk_nxt = blk_cnt;
        if (!stall) begin
            if (any_gnt || !busy_next) begin
                blk_nxt = '0;
            end else if (blk_cnt != LIMIT) begin
                blk_nxt = blk_cnt + 1'b1;
            end
        end
    end

    // round-robin pointer and the broadcast bus register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            bus_data  <= '0;
            bus_addr  <= '0;
            bus_valid <= '0;
        end else if (any_gnt) begin
            ptr       <= win_idx + 1'b1;
            bus_data  <= req_data[win_idx*DATA_LEN +: DATA_LEN];
            bus_addr  <= win_idx;
            bus_valid <= req_dst[win_idx*NUM_PE +: NUM_PE];
        end else begin
            bus_valid <= '0;
        end
    end

    // pending-work flag, stuck counter and its sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            blk_cnt   <= '0;
            err_stuck <= 1'b0;
        end else begin
            busy      <= busy_next;
            blk_cnt   <= blk_nxt;
            err_stuck <= err_stuck | (blk_nxt == LIMIT);
        end
    end

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Self-checking bench for bus_write_arbiter: table vectors,
// directed corner sequences and randomized traffic vs. a model.
module tb_bus_write_arbiter;

    localparam int N   = 8;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int LIM = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            stall = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    dst_full = '0;
    logic [N*DW-1:0] req_data;
    logic [N*N-1:0]  req_dst;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   bus_data;
    logic [AW-1:0]   bus_addr;
    logic [N-1:0]    bus_valid;
    logic            busy;
    logic            err_stuck;

    logic [DW-1:0]   pd   [N];
    logic [N-1:0]    pdst [N];

    int passed = 0;
    int total  = 0;

    // reference model state
    int            m_ptr;
    logic [DW-1:0] m_data;
    int            m_addr;
    logic [N-1:0]  m_valid;
    logic          m_busy;
    int            m_cnt;
    logic          m_err;
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  seen_gnt;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*N-1:0] dst;
        logic [N-1:0]   full;
        logic           stall;
        logic [N-1:0]   e_gnt;
        logic [N-1:0]   e_valid;
        logic [AW-1:0]  e_addr;
    } vec_t;

    vec_t tbl [8];

    bus_write_arbiter #(
        .NUM_PE       (N),
        .DATA_LEN     (DW),
        .BUS_ADDR_LEN (AW),
        .STUCK_LIMIT  (LIM)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .stall     (stall),
        .req       (req),
        .req_data  (req_data),
        .req_dst   (req_dst),
        .dst_full  (dst_full),
        .gnt       (gnt),
        .bus_data  (bus_data),
        .bus_addr  (bus_addr),
        .bus_valid (bus_valid),
        .busy      (busy),
        .err_stuck (err_stuck)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        req_dst  = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = pd[i];
            req_dst[i*N +: N]    = pdst[i];
        end
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // spec-level model: scan upward from ptr for first eligible PE
    task automatic model_step();
        int w;
        w = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                int j;
                logic [N-1:0] d;
                j = (m_ptr + k) % N;
                d = pdst[j];
                if (w < 0 && req[j] && d != 0 && (d & dst_full) == 0)
                    w = j;
            end
        end
        m_gnt = (w >= 0) ? N'(1 << w) : '0;
        if (w >= 0) begin
            m_ptr   = (w + 1) % N;
            m_data  = pd[w];
            m_addr  = w;
            m_valid = pdst[w];
        end else begin
            m_valid = '0;
        end
        m_busy = (req != 0);
        if (!stall) begin
            if (w >= 0 || req == 0) m_cnt = 0;
            else if (m_cnt < LIM) m_cnt = m_cnt + 1;
        end
        if (m_cnt == LIM) m_err = 1'b1;
    endtask

    // one clock: gnt mid-cycle, registered outputs after the edge
    task automatic cycle();
        @(negedge clk);
        model_step();
        seen_gnt = gnt;
        chk("gnt", 64'(gnt), 64'(m_gnt));
        @(posedge clk);
        #1;
        chk("bus_valid", 64'(bus_valid), 64'(m_valid));
        chk("bus_data", 64'(bus_data), 64'(m_data));
        chk("bus_addr", 64'(bus_addr), 64'(m_addr));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("err_stuck", 64'(err_stuck), 64'(m_err));
        chk("ptr", 64'(dut.ptr), 64'(m_ptr));
        chk("blk_cnt", 64'(dut.blk_cnt), 64'(m_cnt));
    endtask

    // async reset mid-cycle; registers must clear before any edge
    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        req      = '0;
        stall    = 1'b0;
        dst_full = '0;
        for (int i = 0; i < N; i++) begin
            pd[i]   = '0;
            pdst[i] = '0;
        end
        #2;
        chk("rst_bus_data", 64'(bus_data), 64'h0);
        chk("rst_bus_addr", 64'(bus_addr), 64'h0);
        chk("rst_bus_valid", 64'(bus_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err_stuck), 64'h0);
        chk("rst_ptr", 64'(dut.ptr), 64'h0);
        chk("rst_blk", 64'(dut.blk_cnt), 64'h0);
        m_ptr   = 0;
        m_data  = '0;
        m_addr  = 0;
        m_valid = '0;
        m_busy  = 1'b0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_gnt   = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] e_data;
        for (int i = 0; i < N; i++) begin
            pd[i]   = '0;
            pdst[i] = '0;
        end

        tbl[0] = '{8'h04, 64'h0000_0000_0010_0000, 8'h00, 1'b0,
                   8'h04, 8'h10, 3'd2};
        tbl[1] = '{8'hFF, 64'h8040_2010_0804_0201, 8'h00, 1'b0,
                   8'h01, 8'h01, 3'd0};
        tbl[2] = '{8'h22, 64'h0000_0100_0000_0800, 8'h08, 1'b0,
                   8'h20, 8'h01, 3'd5};
        tbl[3] = '{8'h03, 64'h0000_0000_0000_0200, 8'h00, 1'b0,
                   8'h02, 8'h02, 3'd1};
        tbl[4] = '{8'h0F, 64'h8040_2010_0804_0201, 8'h00, 1'b1,
                   8'h00, 8'h00, 3'd0};
        tbl[5] = '{8'h80, 64'hF000_0000_0000_0000, 8'h00, 1'b0,
                   8'h80, 8'hF0, 3'd7};
        tbl[6] = '{8'h80, 64'hF000_0000_0000_0000, 8'h10, 1'b0,
                   8'h00, 8'h00, 3'd0};
        tbl[7] = '{8'h00, 64'h8040_2010_0804_0201, 8'h00, 1'b0,
                   8'h00, 8'h00, 3'd0};

        // table vectors, each from a fresh reset (ptr=0)
        for (int v = 0; v < 8; v++) begin
            do_reset();
            req      = tbl[v].req;
            dst_full = tbl[v].full;
            stall    = tbl[v].stall;
            for (int i = 0; i < N; i++) begin
                pd[i]   = 16'hA000 | 16'(i);
                pdst[i] = tbl[v].dst[i*N +: N];
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", v), 64'(gnt), 64'(tbl[v].e_gnt));
            @(posedge clk);
            #1;
            e_data = (tbl[v].e_gnt != 0) ?
                     (16'hA000 | 16'(tbl[v].e_addr)) : 16'h0;
            chk($sformatf("tbl%0d_valid", v), 64'(bus_valid),
                64'(tbl[v].e_valid));
            chk($sformatf("tbl%0d_addr", v), 64'(bus_addr),
                64'(tbl[v].e_addr));
            chk($sformatf("tbl%0d_data", v), 64'(bus_data), 64'(e_data));
        end

        // single request with known word
        do_reset();
        req     = 8'h04;
        pd[2]   = 16'hBEEF;
        pdst[2] = 8'h10;
        cycle();
        chk("single_gnt", 64'(seen_gnt), 64'h04);
        chk("single_data", 64'(bus_data), 64'hBEEF);
        chk("single_addr", 64'(bus_addr), 64'd2);
        chk("single_valid", 64'(bus_valid), 64'h10);
        chk("single_ptr", 64'(dut.ptr), 64'd3);

        // full contention: strict rotation, no gaps
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < N; i++) begin
            pd[i]   = 16'(16'h100 + i);
            pdst[i] = N'(1 << i);
        end
        for (int c = 0; c < 9; c++) begin
            cycle();
            chk($sformatf("fair%0d", c), 64'(seen_gnt),
                64'(1 << (c % N)));
        end

        // backpressure on destination 3
        do_reset();
        req      = 8'h22;
        pdst[1]  = 8'h08;
        pdst[5]  = 8'h01;
        dst_full = 8'h08;
        cycle();
        chk("bp_pe5", 64'(seen_gnt), 64'h20);
        req = 8'h02;
        cycle();
        chk("bp_hold", 64'(seen_gnt), 64'h00);
        dst_full = 8'h00;
        cycle();
        chk("bp_pe1", 64'(seen_gnt), 64'h02);

        // stall freezes the blocked counter
        do_reset();
        req = 8'h0F;
        for (int i = 0; i < 4; i++) pdst[i] = N'(1 << i);
        dst_full = 8'h0F;
        cycle();
        dst_full = 8'h00;
        stall    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("stall_gnt", 64'(seen_gnt), 64'h0);
            chk("stall_valid", 64'(bus_valid), 64'h0);
            chk("stall_blk", 64'(dut.blk_cnt), 64'd1);
        end
        stall = 1'b0;
        cycle();
        chk("unstall_gnt", 64'(seen_gnt), 64'h01);

        // stuck detection at exactly LIM blocked cycles
        do_reset();
        req      = 8'h01;
        pdst[0]  = 8'h01;
        dst_full = 8'h01;
        repeat (LIM - 1) cycle();
        chk("stuck_early", 64'(err_stuck), 64'h0);
        cycle();
        chk("stuck_set", 64'(err_stuck), 64'h1);
        req = 8'h00;
        repeat (3) cycle();
        chk("stuck_sticky", 64'(err_stuck), 64'h1);

        // in-flight word dropped by async reset
        dst_full = 8'h00;
        req      = 8'h04;
        pd[2]    = 16'h1234;
        pdst[2]  = 8'h10;
        cycle();
        chk("inflight_valid", 64'(bus_valid), 64'h10);
        do_reset();

        // zero destination mask never wins
        req     = 8'h03;
        pdst[0] = 8'h00;
        pdst[1] = 8'h02;
        cycle();
        chk("zmask_pe1", 64'(seen_gnt), 64'h02);
        req = 8'h01;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("zmask_none", 64'(seen_gnt), 64'h0);
        end

        // randomized traffic honouring the hold-until-granted rule
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_gnt[i] || !req[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req[i] = 1'b1;
                        pd[i]  = 16'($urandom);
                        if ($urandom_range(0, 9) == 0)
                            pdst[i] = 8'($urandom_range(1, 255));
                        else
                            pdst[i] = 8'(1 << $urandom_range(0, 7));
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            for (int j = 0; j < N; j++)
                dst_full[j] = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
